// File: rtl/snes_pkg.sv
// snes_pkg: shared state encoding and tick-length helper for the SNES pad poller.
package snes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_e;

  function automatic int tick_count(input int clk_ns, input int tick_ns);
    int n;
    n = tick_ns / clk_ns;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/snes_multipad_if.sv
// snes_multipad_if: host-side bundle of the SNES pad poller.
interface snes_multipad_if #(
  parameter int NB_PADS  = 2,
  parameter int REG_SIZE = 16
);

  logic                         start;
  logic                         busy;
  logic                         valid;
  logic [NB_PADS*REG_SIZE-1:0]  vdata;
  logic [NB_PADS-1:0]           changed;

  modport master (
    output start,
    input  busy, valid, vdata, changed
  );

  modport slave (
    input  start,
    output busy, valid, vdata, changed
  );

endinterface

// File: rtl/snes_tick_gen.sv
// snes_tick_gen: one-cycle tick every N clocks; counter held at 0 while disabled.
module snes_tick_gen #(
  parameter int N = 150
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (!en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/snes_multipad.sv
// snes_multipad: polls NB_PADS SNES pads over a shared clock/latch pair.
// Define SNES_PAD_DETECT_EN for present_o, derived from one extra raw bit.
module snes_multipad
  import snes_pkg::*;
#(
  parameter int CLK_PER_NS = 40,
  parameter int TICK_NS    = 6000,
  parameter int NB_PADS    = 2,
  parameter int REG_SIZE   = 16,
  parameter int AUTO_POLL  = 1,
  parameter int POLL_TICKS = 2778,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        dclock_o,
  output logic                        dlatch_o,
  input  logic [NB_PADS-1:0]          sdata_i,
  output logic [NB_PADS*REG_SIZE-1:0] vdata_o,
  output logic                        valid_o,
  output logic [NB_PADS-1:0]          changed_o
`ifdef SNES_PAD_DETECT_EN
  ,
  output logic [NB_PADS-1:0]          present_o
`endif
);

  localparam int NTICK = tick_count(CLK_PER_NS, TICK_NS);
`ifdef SNES_PAD_DETECT_EN
  localparam int NBITS = REG_SIZE + 1;
`else
  localparam int NBITS = REG_SIZE;
`endif
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [BW-1:0] LAST = BW'(NBITS - 1);
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [31:0] PT = 32'(POLL_TICKS);

  state_e state_q, state_d;

  logic                        tick;
  logic                        tick_en;
  logic                        sample;
  logic                        go;
  logic                        poll_go;
  logic                        poll_late;
  logic                        armed_q;
  logic                        half_q;
  logic [BW-1:0]               bit_q;
  logic [31:0]                 poll_q;
  logic [NB_PADS*REG_SIZE-1:0] shadow_q;
`ifdef SNES_PAD_DETECT_EN
  logic [NB_PADS-1:0]          extra_q;
`endif

  // an overdue poll skips the tick wait and restarts the tick phase
  assign poll_late = (poll_q >= PT);
  assign poll_go = poll_late ||
                   (tick && (!armed_q || poll_q >= PT - 32'd1));
  assign go = (AUTO_POLL != 0) ? poll_go : start_i;
  assign tick_en = (AUTO_POLL != 0) ?
                   !(state_q == ST_IDLE && poll_late) :
                   (state_q != ST_IDLE);

  snes_tick_gen #(
    .N(NTICK)
  ) u_tick (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .en_i  (tick_en),
    .tick_o(tick)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dclock_o = 1'b1;
    dlatch_o = 1'b0;
    busy_o   = 1'b1;
    sample   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (go) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        dlatch_o = 1'b1;
        if (tick && half_q) begin
          sample  = 1'b1;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        dclock_o = 1'b0;
        if (tick) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (tick) begin
          sample  = 1'b1;
          state_d = (bit_q == LAST) ? ST_DONE : ST_LOW;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vdata_o   <= '0;
      valid_o   <= 1'b0;
      changed_o <= '0;
      shadow_q  <= '0;
      bit_q     <= '0;
      half_q    <= 1'b0;
      poll_q    <= '0;
      armed_q   <= 1'b0;
`ifdef SNES_PAD_DETECT_EN
      extra_q   <= '0;
      present_o <= '0;
`endif
    end else begin
      valid_o <= 1'b0;
      if (state_q == ST_IDLE) begin
        bit_q  <= '0;
        half_q <= 1'b0;
      end
      if (state_q == ST_LATCH && tick) half_q <= 1'b1;
      if (state_q == ST_IDLE && go) begin
        poll_q  <= '0;
        armed_q <= 1'b1;
      end else if (tick && !poll_late) begin
        poll_q <= poll_q + 32'd1;
      end
      if (sample) begin
        bit_q <= bit_q + BW'(1);
        for (int p = 0; p < NB_PADS; p++) begin
          for (int k = 0; k < REG_SIZE; k++) begin
            if (bit_q == BW'(k))
              shadow_q[p*REG_SIZE+k] <= sdata_i[p] ^ INV;
          end
`ifdef SNES_PAD_DETECT_EN
          if (bit_q == BW'(REG_SIZE)) extra_q[p] <= sdata_i[p];
`endif
        end
      end
      if (state_q == ST_DONE) begin
        valid_o <= 1'b1;
        vdata_o <= shadow_q;
        for (int p = 0; p < NB_PADS; p++) begin
          changed_o[p] <= shadow_q[p*REG_SIZE +: REG_SIZE] !=
                          vdata_o[p*REG_SIZE +: REG_SIZE];
`ifdef SNES_PAD_DETECT_EN
          present_o[p] <= ~extra_q[p];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_snes_multipad.sv
// tb_snes_multipad: directed checks of frame timing, decode, change flags,
// start/reset handling (dut0, start_i driven) and free-running polling (dut1).
module tb_snes_multipad;

  localparam int NP = 2;
  localparam int RS = 16;
`ifdef SNES_PAD_DETECT_EN
  localparam int EXP_PULSES = 16;
`else
  localparam int EXP_PULSES = 15;
`endif

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rstn0, rstn1;
  logic dclock0, dlatch0, dclock1, dlatch1, busy1, valid1;
  logic [NP-1:0] sdata0, sdata1, changed1;
  logic [NP*RS-1:0] vdata1;
`ifdef SNES_PAD_DETECT_EN
  logic [NP-1:0] present0, present1;
`endif

  snes_multipad_if #(.NB_PADS(NP), .REG_SIZE(RS)) bus0 ();

  logic [15:0] pw0, pw1;
  logic [1:0]  pext;
  logic [4:0]  pidx = '0;
  logic        dprev = 1'b1;

  int errors = 0;
  int checks = 0;

  snes_multipad #(
    .CLK_PER_NS(40), .TICK_NS(200), .NB_PADS(NP), .REG_SIZE(RS),
    .AUTO_POLL(0), .POLL_TICKS(40), .ACTIVE_LOW(1)
  ) dut0 (
    .clk_i(clk), .rstn_i(rstn0), .start_i(bus0.start),
    .busy_o(bus0.busy), .dclock_o(dclock0), .dlatch_o(dlatch0),
    .sdata_i(sdata0), .vdata_o(bus0.vdata), .valid_o(bus0.valid),
    .changed_o(bus0.changed)
`ifdef SNES_PAD_DETECT_EN
    , .present_o(present0)
`endif
  );

  snes_multipad #(
    .CLK_PER_NS(40), .TICK_NS(200), .NB_PADS(NP), .REG_SIZE(RS),
    .AUTO_POLL(1), .POLL_TICKS(40), .ACTIVE_LOW(1)
  ) dut1 (
    .clk_i(clk), .rstn_i(rstn1), .start_i(1'b0),
    .busy_o(busy1), .dclock_o(dclock1), .dlatch_o(dlatch1),
    .sdata_i(sdata1), .vdata_o(vdata1), .valid_o(valid1),
    .changed_o(changed1)
`ifdef SNES_PAD_DETECT_EN
    , .present_o(present1)
`endif
  );

  // pad model: latch reloads, each dclock rise shifts to the next bit
  always @(negedge clk) begin
    if (dlatch0) pidx <= '0;
    else if (dclock0 && !dprev) pidx <= pidx + 5'd1;
    dprev <= dclock0;
  end

  always_comb begin
    sdata0 = pext;
    if (pidx < 5'd16) begin
      sdata0[0] = pw0[pidx[3:0]];
      sdata0[1] = pw1[pidx[3:0]];
    end
  end

  assign sdata1 = 2'b01;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int inj, input int stop_at,
                           output int lat, output int pul,
                           output int lmin, output int lmax,
                           output int vals, output logic fin,
                           output logic bsy);
    int lowlen;
    int rises;
    logic pclk;
    logic injd;
    lat = 0; pul = 0; lmin = 1000; lmax = 0; vals = 0;
    lowlen = 0; rises = 0; pclk = 1'b1; fin = 1'b0; injd = 1'b0;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bsy = bus0.busy;
    for (int n = 0; n < 400; n++) begin
      if (dlatch0) lat++;
      if (!dclock0) lowlen++;
      if (pclk && !dclock0) pul++;
      if (!pclk && dclock0) begin
        rises++;
        if (lowlen < lmin) lmin = lowlen;
        if (lowlen > lmax) lmax = lowlen;
        lowlen = 0;
      end
      pclk = dclock0;
      if (bus0.valid) vals++;
      if (bus0.valid || (stop_at != 0 && rises == stop_at)) begin
        fin = 1'b1;
        break;
      end
      if (inj != 0 && rises == inj && !injd) begin
        bus0.start = 1'b1;
        injd = 1'b1;
      end
      @(negedge clk);
      bus0.start = 1'b0;
    end
  endtask

  task automatic idle_run(input int cyc, output int lat, output int vals);
    lat = 0;
    vals = 0;
    for (int n = 0; n < cyc; n++) begin
      @(negedge clk);
      if (dlatch0) lat++;
      if (bus0.valid) vals++;
    end
  endtask

  int lat, pul, lmin, lmax, vals;
  logic fin, bsy;
  int t, k, v1;
  int rise[3];
  logic lprev;

  initial begin
    rstn0 = 1'b0;
    rstn1 = 1'b0;
    bus0.start = 1'b0;
    pw0 = 16'h0001;
    pw1 = 16'hFFFF;
    pext = 2'b10;
    repeat (3) @(negedge clk);

    check("rst_dclock", 32'(dclock0), 32'd1);
    check("rst_dlatch", 32'(dlatch0), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_vdata", bus0.vdata, 32'd0);
    check("rst_valid", 32'(bus0.valid), 32'd0);
    check("rst_changed", 32'(bus0.changed), 32'd0);

    // free-running poller: first frame one tick after release, then every 200
    rstn0 = 1'b1;
    rstn1 = 1'b1;
    t = 0; k = 0; v1 = 0; lprev = 1'b0;
    while (k < 3 && t < 700) begin
      @(negedge clk);
      t++;
      if (dlatch1 && !lprev) begin
        rise[k] = t;
        k++;
      end
      if (valid1) v1++;
      lprev = dlatch1;
    end
    check("auto_rises", 32'(k), 32'd3);
    check("auto_first", 32'(rise[0]), 32'd5);
    check("auto_period1", 32'(rise[1] - rise[0]), 32'd200);
    check("auto_period2", 32'(rise[2] - rise[1]), 32'd200);
    check("auto_valids", 32'(v1), 32'd2);
    check("auto_vdata", vdata1, 32'hFFFF_0000);

    // frame 1
    run_frame(0, 0, lat, pul, lmin, lmax, vals, fin, bsy);
    check("f1_done", 32'(fin), 32'd1);
    check("f1_busy", 32'(bsy), 32'd1);
    check("f1_latch", 32'(lat), 32'd10);
    check("f1_pulses", 32'(pul), 32'(EXP_PULSES));
    check("f1_lowmin", 32'(lmin), 32'd5);
    check("f1_lowmax", 32'(lmax), 32'd5);
    check("f1_valid", 32'(vals), 32'd1);
    check("f1_vdata", bus0.vdata, 32'h0000_FFFE);
    check("f1_changed", 32'(bus0.changed), 32'h1);
`ifdef SNES_PAD_DETECT_EN
    check("f1_present", 32'(present0), 32'h1);
`endif
    @(negedge clk);
    check("f1_valid_once", 32'(bus0.valid), 32'd0);
    check("f1_idle_busy", 32'(bus0.busy), 32'd0);

    // identical frame
    run_frame(0, 0, lat, pul, lmin, lmax, vals, fin, bsy);
    check("f2_done", 32'(fin), 32'd1);
    check("f2_vdata", bus0.vdata, 32'h0000_FFFE);
    check("f2_changed", 32'(bus0.changed), 32'h0);

    // pad1 changes
    pw1 = 16'hFFF7;
    run_frame(0, 0, lat, pul, lmin, lmax, vals, fin, bsy);
    check("f3_done", 32'(fin), 32'd1);
    check("f3_vhi", 32'(bus0.vdata[31:16]), 32'h0008);
    check("f3_vlo", 32'(bus0.vdata[15:0]), 32'hFFFE);
    check("f3_changed", 32'(bus0.changed), 32'h2);
    idle_run(20, lat, vals);
    check("f3_changed_hold", 32'(bus0.changed), 32'h2);

    // start during HIGH of bit 5 is ignored
    run_frame(5, 0, lat, pul, lmin, lmax, vals, fin, bsy);
    check("inj_done", 32'(fin), 32'd1);
    check("inj_valid", 32'(vals), 32'd1);
    check("inj_changed", 32'(bus0.changed), 32'h0);
    idle_run(300, lat, vals);
    check("inj_no_latch", 32'(lat), 32'd0);
    check("inj_no_valid", 32'(vals), 32'd0);

    // reset during bit 8
    pw1 = 16'hFFFF;
    run_frame(0, 8, lat, pul, lmin, lmax, vals, fin, bsy);
    check("mid_reached", 32'(fin), 32'd1);
    check("mid_busy_pre", 32'(bus0.busy), 32'd1);
    rstn0 = 1'b0;
    #1;
    check("mid_dclock", 32'(dclock0), 32'd1);
    check("mid_dlatch", 32'(dlatch0), 32'd0);
    check("mid_busy", 32'(bus0.busy), 32'd0);
    check("mid_vdata", bus0.vdata, 32'd0);
    check("mid_valid", 32'(bus0.valid), 32'd0);
    check("mid_changed", 32'(bus0.changed), 32'd0);
    repeat (2) @(negedge clk);
    rstn0 = 1'b1;
    idle_run(100, lat, vals);
    check("mid_no_valid", 32'(vals), 32'd0);
    check("mid_no_latch", 32'(lat), 32'd0);

    run_frame(0, 0, lat, pul, lmin, lmax, vals, fin, bsy);
    check("clean_done", 32'(fin), 32'd1);
    check("clean_pulses", 32'(pul), 32'(EXP_PULSES));
    check("clean_vdata", bus0.vdata, 32'h0000_FFFE);
    check("clean_changed", 32'(bus0.changed), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
